dram_arbiter: RTL and testbench

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 157 +++++++++++++++
 tb/tb_dram_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// Two-requester round-robin arbiter onto a single-outstanding
// AXI-like DRAM master port, with latency and error reporting.
module dram_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    input  logic [1:0]   req_write,
    input  logic [25:0]  req_addr,
    input  logic [127:0] req_wdata,
    output logic [1:0]   req_ack,
    output logic [1:0]   done,
    output logic [63:0]  rdata,
    output logic         err,
    output logic [15:0]  lat,
    output logic         AR_VALID,
    output logic [31:0]  AR_ADDR,
    input  logic         AR_READY,
    input  logic         R_VALID,
    input  logic [63:0]  R_DATA,
    input  logic [1:0]   R_RESP,
    output logic         R_READY,
    output logic         AW_VALID,
    output logic [31:0]  AW_ADDR,
    input  logic         AW_READY,
    output logic         W_VALID,
    output logic [63:0]  W_DATA,
    input  logic         W_READY,
    input  logic         B_VALID,
    input  logic [1:0]   B_RESP,
    output logic         B_READY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t      state;
    logic        gnt;
    logic        gnt_q;
    logic        last;
    logic [63:0] wdata_q;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic [12:0] sel_addr;
    logic [1:0]  gnt_oh;

    // On a tie the requester that was not served last wins.
    assign gnt      = (&req_valid) ? ~last : req_valid[1];
    assign sel_addr = gnt ? req_addr[25:13] : req_addr[12:0];
    assign gnt_oh   = gnt_q ? 2'b10 : 2'b01;
    assign cnt_inc  = (&cnt) ? cnt : cnt + 16'd1;

    // Transaction FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            gnt_q    <= 1'b0;
            last     <= 1'b1;
            wdata_q  <= '0;
            cnt      <= '0;
            req_ack  <= '0;
            done     <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            lat      <= '0;
            AR_VALID <= 1'b0;
            AR_ADDR  <= '0;
            R_READY  <= 1'b0;
            AW_VALID <= 1'b0;
            AW_ADDR  <= '0;
            W_VALID  <= 1'b0;
            W_DATA   <= '0;
            B_READY  <= 1'b0;
        end else begin
            req_ack <= '0;
            done    <= '0;
            err     <= 1'b0;
            cnt     <= cnt_inc;
            unique case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        gnt_q   <= gnt;
                        req_ack <= gnt ? 2'b10 : 2'b01;
                        wdata_q <= gnt ? req_wdata[127:64]
                                       : req_wdata[63:0];
                        cnt     <= '0;
                        if (req_write[gnt]) begin
                            state    <= S_AW;
                            AW_VALID <= 1'b1;
                            AW_ADDR  <= {19'b0, sel_addr};
                        end else begin
                            state    <= S_AR;
                            AR_VALID <= 1'b1;
                            AR_ADDR  <= {19'b0, sel_addr};
                        end
                    end
                end
                S_AR: begin
                    if (AR_READY) begin
                        AR_VALID <= 1'b0;
                        AR_ADDR  <= '0;
                        R_READY  <= 1'b1;
                        state    <= S_R;
                    end
                end
                S_R: begin
                    if (R_VALID && R_READY) begin
                        R_READY <= 1'b0;
                        rdata   <= R_DATA;
                        err     <= |R_RESP;
                        done    <= gnt_oh;
                        lat     <= cnt_inc;
                        state   <= S_DONE;
                    end
                end
                S_AW: begin
                    if (AW_READY) begin
                        AW_VALID <= 1'b0;
                        AW_ADDR  <= '0;
                        W_VALID  <= 1'b1;
                        W_DATA   <= wdata_q;
                        state    <= S_W;
                    end
                end
                S_W: begin
                    if (W_READY) begin
                        W_VALID <= 1'b0;
                        W_DATA  <= '0;
                        B_READY <= 1'b1;
                        state   <= S_B;
                    end
                end
                S_B: begin
                    if (B_VALID) begin
                        B_READY <= 1'b0;
                        err     <= |B_RESP;
                        done    <= gnt_oh;
                        lat     <= cnt_inc;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    last  <= gnt_q;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a DRAM slave model
// (fixed or random handshake delays) and a protocol monitor.
module tb_dram_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_write = '0;
  logic [25:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [1:0]   req_ack;
  logic [1:0]   done;
  logic [63:0]  rdata;
  logic         err;
  logic [15:0]  lat;
  logic         AR_VALID;
  logic [31:0]  AR_ADDR;
  logic         AR_READY = 1'b0;
  logic         R_VALID = 1'b0;
  logic [63:0]  R_DATA = '0;
  logic [1:0]   R_RESP = '0;
  logic         R_READY;
  logic         AW_VALID;
  logic [31:0]  AW_ADDR;
  logic         AW_READY = 1'b0;
  logic         W_VALID;
  logic [63:0]  W_DATA;
  logic         W_READY = 1'b0;
  logic         B_VALID = 1'b0;
  logic [1:0]   B_RESP = '0;
  logic         B_READY;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_cyc = 0;

  logic [63:0] mem [0:8191];
  logic        rnd = 1'b0;
  int          fix_d = 0;
  logic [1:0]  rresp = 2'b00;

  dram_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .done(done), .rdata(rdata),
    .err(err), .lat(lat),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR),
    .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA),
    .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR),
    .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA),
    .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP),
    .B_READY(B_READY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string t, input logic ok,
                     input logic [127:0] o,
                     input logic [127:0] e);
    n_chk++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  function automatic int pick();
    return rnd ? int'($urandom_range(49, 2)) : fix_d;
  endfunction

  logic        ar_act = 0, aw_act = 0, w_act = 0;
  logic        r_pend = 0, b_pend = 0;
  int          ar_cnt, ar_tgt, aw_cnt, aw_tgt, w_cnt, w_tgt;
  int          r_cnt, r_tgt, b_cnt, b_tgt;
  logic [12:0] ar_a = '0, aw_a = '0;
  logic [63:0] w_d = '0;
  logic        p_rst = 1'b1, p_arv = 0, p_awv = 0, p_wv = 0;
  logic [31:0] p_ara = '0, p_awa = '0;
  logic [63:0] p_wd = '0;

  always @(negedge clk) begin
    if (!rst && !p_rst) begin
      if (!AR_VALID)
        chk("ar_addr_idle", AR_ADDR === 32'h0,
            AR_ADDR, 0);
      if (!AW_VALID)
        chk("aw_addr_idle", AW_ADDR === 32'h0,
            AW_ADDR, 0);
      if (!W_VALID)
        chk("w_data_idle", W_DATA === 64'h0,
            W_DATA, 0);
      chk("rready_with_arvalid",
          (R_READY & AR_VALID) === 1'b0,
          R_READY & AR_VALID, 0);
      chk("wvalid_with_awvalid",
          (W_VALID & AW_VALID) === 1'b0,
          W_VALID & AW_VALID, 0);
      if (p_arv && !AR_READY) begin
        chk("ar_valid_stable", AR_VALID === 1'b1,
            AR_VALID, 1);
        chk("ar_addr_stable", AR_ADDR === p_ara,
            AR_ADDR, p_ara);
      end
      if (p_awv && !AW_READY) begin
        chk("aw_valid_stable", AW_VALID === 1'b1,
            AW_VALID, 1);
        chk("aw_addr_stable", AW_ADDR === p_awa,
            AW_ADDR, p_awa);
      end
      if (p_wv && !W_READY) begin
        chk("w_valid_stable", W_VALID === 1'b1,
            W_VALID, 1);
        chk("w_data_stable", W_DATA === p_wd,
            W_DATA, p_wd);
      end
    end
    p_rst = rst;
    p_arv = AR_VALID; p_ara = AR_ADDR;
    p_awv = AW_VALID; p_awa = AW_ADDR;
    p_wv  = W_VALID;  p_wd  = W_DATA;
    if (rst) begin
      AR_READY = 0; R_VALID = 0; R_DATA = '0;
      R_RESP = '0; AW_READY = 0; W_READY = 0;
      B_VALID = 0; B_RESP = '0;
      ar_act = 0; aw_act = 0; w_act = 0;
      r_pend = 0; b_pend = 0;
    end else begin
      if (AR_READY) begin
        AR_READY = 0; r_pend = 1; r_cnt = 0;
        r_tgt = pick();
      end else if (AR_VALID) begin
        if (!ar_act) begin
          ar_act = 1; ar_cnt = 0; ar_tgt = pick();
        end
        if (ar_cnt >= ar_tgt) begin
          AR_READY = 1; ar_a = AR_ADDR[12:0];
          ar_act = 0;
        end else ar_cnt++;
      end
      if (R_VALID) begin
        R_VALID = 0; R_DATA = '0; R_RESP = '0;
      end else if (r_pend) begin
        if (r_cnt >= r_tgt) begin
          R_VALID = 1; R_DATA = mem[ar_a];
          R_RESP = rresp; r_pend = 0;
        end else r_cnt++;
      end
      if (AW_READY) begin
        AW_READY = 0;
      end else if (AW_VALID) begin
        if (!aw_act) begin
          aw_act = 1; aw_cnt = 0; aw_tgt = pick();
        end
        if (aw_cnt >= aw_tgt) begin
          AW_READY = 1; aw_a = AW_ADDR[12:0];
          aw_act = 0;
        end else aw_cnt++;
      end
      if (W_READY) begin
        W_READY = 0; mem[aw_a] = w_d;
        b_pend = 1; b_cnt = 0; b_tgt = pick();
      end else if (W_VALID) begin
        if (!w_act) begin
          w_act = 1; w_cnt = 0; w_tgt = pick();
        end
        if (w_cnt >= w_tgt) begin
          W_READY = 1; w_d = W_DATA; w_act = 0;
        end else w_cnt++;
      end
      if (B_VALID) begin
        B_VALID = 0; B_RESP = '0;
      end else if (b_pend) begin
        if (b_cnt >= b_tgt) begin
          B_VALID = 1; B_RESP = 2'b00; b_pend = 0;
        end else b_cnt++;
      end
    end
  end

  task automatic wait_ack(input logic [1:0] exp,
                          input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (req_ack === 2'b00 && n < 300);
    chk(tag, req_ack === exp, req_ack, exp);
    ack_cyc = cyc;
  endtask

  task automatic wait_done(input logic [1:0] exp,
                           input string tag);
    int n = 0;
    logic saw_ack = 1'b0;
    do begin
      @(negedge clk); n++;
      if (req_ack !== 2'b00) saw_ack = 1'b1;
    end while (done === 2'b00 && n < 300);
    chk(tag, done === exp, done, exp);
    chk("ack_while_busy", saw_ack === 1'b0,
        saw_ack, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    logic [9:0] v;
    v = {req_ack, done, err, AR_VALID, R_READY,
         AW_VALID, W_VALID, B_READY};
    chk(tag, v === 10'h0, v, 0);
    chk("rst_rdata", rdata === 64'h0, rdata, 0);
    chk("rst_lat", lat === 16'h0, lat, 0);
    chk("rst_addr", {AR_ADDR, AW_ADDR} === 64'h0,
        {AR_ADDR, AW_ADDR}, 0);
    chk("rst_wdata", W_DATA === 64'h0, W_DATA, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[13'h0005] = 64'hDEADBEEF00000001;
    mem[13'h00AA] = 64'h1111;
    mem[13'h0155] = 64'h2222;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst = 1'b0;

    fix_d = 3;
    req_valid = 2'b01; req_write = 2'b00;
    req_addr = {13'h0, 13'h0005};
    wait_ack(2'b01, "rd0_ack");
    chk("rd0_ar_valid", AR_VALID === 1'b1, AR_VALID, 1);
    chk("rd0_ar_addr", AR_ADDR === 32'h5, AR_ADDR, 5);
    req_valid = 2'b00;
    wait_done(2'b01, "rd0_done");
    chk("rd0_rdata", rdata === 64'hDEADBEEF00000001,
        rdata, 64'hDEADBEEF00000001);
    chk("rd0_err", err === 1'b0, err, 0);
    chk("rd0_lat", lat === 16'd8, lat, 8);

    fix_d = 0;
    req_valid = 2'b10; req_write = 2'b10;
    req_addr = {13'h1FFF, 13'h0};
    req_wdata = {64'hA5A5, 64'h0};
    wait_ack(2'b10, "wr1_ack");
    chk("wr1_aw_valid", AW_VALID === 1'b1, AW_VALID, 1);
    chk("wr1_aw_addr", AW_ADDR === 32'h1FFF,
        AW_ADDR, 32'h1FFF);
    req_valid = 2'b00;
    @(negedge clk);
    chk("wr1_w_valid", W_VALID === 1'b1, W_VALID, 1);
    chk("wr1_w_data", W_DATA === 64'hA5A5,
        W_DATA, 64'hA5A5);
    @(negedge clk);
    chk("wr1_b_ready", B_READY === 1'b1, B_READY, 1);
    wait_done(2'b10, "wr1_done");
    chk("wr1_rdata_kept",
        rdata === 64'hDEADBEEF00000001,
        rdata, 64'hDEADBEEF00000001);
    chk("wr1_lat", lat === 16'd3, lat, 3);

    req_valid = 2'b01; req_write = 2'b00;
    req_addr = {13'h0, 13'h1FFF};
    wait_ack(2'b01, "rdback_ack");
    req_valid = 2'b00;
    wait_done(2'b01, "rdback_done");
    chk("rdback_rdata", rdata === 64'hA5A5,
        rdata, 64'hA5A5);
    chk("rdback_lat", lat === 16'd2, lat, 2);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11; req_write = 2'b00;
    req_addr = {13'h0155, 13'h00AA};
    for (int i = 0; i < 4; i++) begin
      logic [63:0] exp_d;
      exp_d = (i % 2 == 0) ? 64'h1111 : 64'h2222;
      wait_ack((i % 2 == 0) ? 2'b01 : 2'b10, "rr_ack");
      if (i == 3) req_valid = 2'b00;
      wait_done((i % 2 == 0) ? 2'b01 : 2'b10, "rr_done");
      chk("rr_rdata", rdata === exp_d, rdata, exp_d);
    end

    rnd = 1'b1;
    req_valid = 2'b01; req_write = 2'b01;
    req_addr = {13'h0, 13'h0300};
    req_wdata = {64'h0, 64'h0123456789ABCDEF};
    wait_ack(2'b01, "rw_ack");
    req_valid = 2'b00;
    wait_done(2'b01, "rw_done");
    chk("rw_err", err === 1'b0, err, 0);
    chk("rw_lat", lat === 16'(cyc - ack_cyc),
        lat, 16'(cyc - ack_cyc));

    rresp = 2'b10;
    req_valid = 2'b10; req_write = 2'b00;
    req_addr = {13'h0300, 13'h0};
    wait_ack(2'b10, "rerr_ack");
    req_valid = 2'b00;
    wait_done(2'b10, "rerr_done");
    chk("rerr_err", err === 1'b1, err, 1);
    chk("rerr_rdata", rdata === 64'h0123456789ABCDEF,
        rdata, 64'h0123456789ABCDEF);
    chk("rerr_lat", lat === 16'(cyc - ack_cyc),
        lat, 16'(cyc - ack_cyc));
    rresp = 2'b00;

    req_valid = 2'b01;
    req_addr = {13'h0, 13'h0005};
    wait_ack(2'b01, "rr2_ack");
    req_valid = 2'b00;
    wait_done(2'b01, "rr2_done");
    chk("rr2_err", err === 1'b0, err, 0);
    chk("rr2_rdata", rdata === 64'hDEADBEEF00000001,
        rdata, 64'hDEADBEEF00000001);
    chk("rr2_lat", lat === 16'(cyc - ack_cyc),
        lat, 16'(cyc - ack_cyc));

    rnd = 1'b0; fix_d = 5;
    req_valid = 2'b10; req_write = 2'b10;
    req_addr = {13'h0040, 13'h0};
    req_wdata = {64'h77, 64'h0};
    wait_ack(2'b10, "abort_ack");
    req_valid = 2'b00;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!B_READY && n < 100);
    end
    chk("abort_in_b", B_READY === 1'b1, B_READY, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort_outputs");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", done === 2'b00, done, 0);
    end

    fix_d = 0;
    req_valid = 2'b01; req_write = 2'b00;
    req_addr = {13'h0, 13'h0005};
    wait_ack(2'b01, "post_ack");
    req_valid = 2'b00;
    wait_done(2'b01, "post_done");
    chk("post_rdata", rdata === 64'hDEADBEEF00000001,
        rdata, 64'hDEADBEEF00000001);
    chk("post_err", err === 1'b0, err, 0);
    chk("post_lat", lat === 16'd2, lat, 2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
